// File: rtl/fir_pkg.sv
// Shared types and helpers for the single-MAC FIR tap sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int IDX_W = 5;

  // Headroom for NTAPS full-width products, so the running sum never wraps.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample history x[0..NTAPS-1] (x[0] newest) with a single combinational read port.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS = 16,
  parameter int DW    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_shift,
  input  logic signed [DW-1:0] i_sample,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output logic signed [DW-1:0] o_rd_data
);

  logic [NTAPS-1:0][DW-1:0] x_q;
  logic [NTAPS-1:0][DW-1:0] x_d;

  for (genvar g = 0; g < NTAPS; g++) begin : g_tap
    if (g == 0) begin : g_head
      assign x_d[g] = i_sample;
    end else begin : g_body
      assign x_d[g] = x_q[g-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        x_q <= '0;
    else if (i_shift) x_q <= x_d;
  end

  // One-hot style mux keeps the read in range for non power-of-two NTAPS.
  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (i_rd_idx == IDX_W'(i)) o_rd_data = x_q[i];
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Single-MAC FIR controller: accept sample, walk coefficient ROM, accumulate, hand off result.
// Optional build macro FIR_SATURATE_EN clamps the output instead of wrapping it.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = 16,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int SHIFT = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic signed [DW-1:0] i_sample,
  input  logic                 i_sample_valid,
  output logic                 o_sample_ready,
  output logic [IDX_W-1:0]     o_idx,
  input  logic signed [CW-1:0] i_tap,
  output logic signed [DW-1:0] o_result,
  output logic                 o_result_valid,
  input  logic                 i_result_ready,
  output logic                 o_busy,
  output logic                 o_sat
);

  localparam int AW = acc_width(DW, CW, NTAPS);
  localparam int PW = DW + CW;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [PW-1:0]  prod_q, prod_d;
  logic signed [DW-1:0]  result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  sat_q, sat_d;

  logic                  shift_en;
  logic signed [DW-1:0]  x_rd;
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  shifted;
  logic signed [DW-1:0]  reduced;
  logic                  clamp;

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_hist (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_shift   (shift_en),
    .i_sample  (i_sample),
    .i_rd_idx  (idx_q),
    .o_rd_data (x_rd)
  );

  // The product register lags the index by one cycle, so DRAIN folds in the last one.
  assign sum     = acc_q + AW'(prod_q);
  assign shifted = sum >>> SHIFT;

`ifdef FIR_SATURATE_EN
  always_comb begin
    clamp = (shifted[AW-1:DW-1] != {(AW-DW+1){shifted[AW-1]}});
    if (!clamp)            reduced = shifted[DW-1:0];
    else if (shifted[AW-1]) reduced = {1'b1, {(DW-1){1'b0}}};
    else                   reduced = {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign clamp   = 1'b0;
  assign reduced = shifted[DW-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    result_d = result_q;
    valid_d  = valid_q;
    sat_d    = sat_q;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_sample_valid) begin
          shift_en = 1'b1;
          acc_d    = '0;
          prod_d   = '0;
          idx_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        prod_d = PW'(i_tap) * PW'(x_rd);
        acc_d  = acc_q + AW'(prod_q);
        if (idx_q == IDX_W'(NTAPS - 1)) state_d = DRAIN;
        else                            idx_d   = idx_q + IDX_W'(1);
      end
      DRAIN: begin
        result_d = reduced;
        sat_d    = clamp;
        valid_d  = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        if (i_result_ready) begin
          valid_d = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
    end
  end

  assign o_sample_ready = (state_q == IDLE);
  assign o_busy         = (state_q != IDLE);
  assign o_idx          = idx_q;
  assign o_result       = result_q;
  assign o_result_valid = valid_q;
  assign o_sat          = sat_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a sum-of-products reference model.
module tb_fir_tap_sequencer;

  localparam int NTAPS = 16;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int SHIFT = 0;
  localparam longint MAXV = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (DW - 1));

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] smp = '0;
  logic                 sv  = 1'b0;
  logic                 rr  = 1'b1;
  logic                 rdy, rv, busy, sat;
  logic [4:0]           idx;
  logic signed [CW-1:0] tap;
  logic signed [DW-1:0] res;
  logic signed [CW-1:0] taps [NTAPS];

  int     n_chk = 0, n_fail = 0, cyc = 0, hs_cyc = 0;
  bit     checking = 1'b0;
  longint hist [NTAPS];
  bit     m_busy = 1'b0;
  int     m_t = 0;
  longint m_exp = 0;
  bit     m_sat = 1'b0;
  longint got [$];
  bit     gsat [$];
  int     acc_times [$];

  always #5 clk = ~clk;

  fir_tap_sequencer #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .SHIFT(SHIFT)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample       (smp),
    .i_sample_valid (sv),
    .o_sample_ready (rdy),
    .o_idx          (idx),
    .i_tap          (tap),
    .o_result       (res),
    .o_result_valid (rv),
    .i_result_ready (rr),
    .o_busy         (busy),
    .o_sat          (sat)
  );

  assign tap = (idx < NTAPS) ? taps[idx] : '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: y = sum tap[i]*x[i] over the history including the new sample.
  function automatic void predict(input longint s, output longint e, output bit st);
    longint acc, sh;
    logic [DW-1:0] lo;
    acc = longint'(taps[0]) * s;
    for (int i = 1; i < NTAPS; i++) acc += longint'(taps[i]) * hist[i-1];
    sh = acc >>> SHIFT;
    st = 1'b0;
    lo = sh[DW-1:0];
`ifdef FIR_SATURATE_EN
    if (sh > MAXV)      begin e = MAXV; st = 1'b1; end
    else if (sh < MINV) begin e = MINV; st = 1'b1; end
    else                e = sh;
`else
    e = longint'($signed(lo));
`endif
  endfunction

  // Transaction-level model: idle / t edges since accept / awaiting handshake.
  always @(posedge clk or posedge rst) begin : model
    longint e;
    bit st;
    if (rst) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      for (int i = 0; i < NTAPS; i++) hist[i] <= 0;
    end else if (!m_busy) begin
      if (sv) begin
        predict(longint'(smp), e, st);
        m_exp  <= e;
        m_sat  <= st;
        m_busy <= 1'b1;
        m_t    <= 0;
        hist[0] <= longint'(smp);
        for (int i = 1; i < NTAPS; i++) hist[i] <= hist[i-1];
      end
    end else if (m_t >= NTAPS + 1 && rr) begin
      m_busy <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && rv && rr) begin
      got.push_back(longint'(res));
      gsat.push_back(sat);
      hs_cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      if (rst) begin
        chk("rst_idx", idx, 0);
        chk("rst_result", res, 0);
        chk("rst_valid", rv, 0);
        chk("rst_sat", sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", rdy, 1);
      end else if (!m_busy) begin
        chk("idle_ready", rdy, 1);
        chk("idle_busy", busy, 0);
        chk("idle_valid", rv, 0);
        chk("idle_idx", idx, 0);
      end else if (m_t < NTAPS) begin
        chk("mac_ready", rdy, 0);
        chk("mac_busy", busy, 1);
        chk("mac_valid", rv, 0);
        chk("mac_idx", idx, m_t);
      end else if (m_t == NTAPS) begin
        chk("drain_ready", rdy, 0);
        chk("drain_busy", busy, 1);
        chk("drain_valid", rv, 0);
      end else begin
        chk("out_ready", rdy, 0);
        chk("out_busy", busy, 1);
        chk("out_valid", rv, 1);
        chk("out_result", longint'(res), m_exp);
        chk("out_sat", sat, m_sat);
      end
    end
  end

  task automatic send(input longint s);
    bit ok = 1'b0;
    sv  = 1'b1;
    smp = DW'(s);
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rdy) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    sv = 1'b0;
    acc_times.push_back(cyc);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_result();
    int n0 = got.size();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (got.size() > n0) ok = 1'b1;
    end
    if (!ok) chk("result_timeout", 0, 1);
  endtask

  task automatic feed(input longint s);
    send(s);
    wait_result();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n;
    bit ok;
    for (int i = 0; i < NTAPS; i++) begin
      taps[i] = 16'sd1;
      hist[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 checking = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Impulse response with unit taps
    got.delete();
    feed(1);
    repeat (16) feed(0);
    for (int i = 0; i < 16; i++) chk("impulse", got[i], 1);
    chk("impulse_tail", got[16], 0);

    // Step response and back-to-back throughput
    pulse_reset();
    got.delete();
    acc_times.delete();
    repeat (20) feed(100);
    for (int i = 0; i < 20; i++) chk("step", got[i], 100 * ((i < 16) ? i + 1 : 16));
    chk("throughput", acc_times[1] - acc_times[0], 19);

    // Ramp taps: impulse must read back the coefficients in index order
    pulse_reset();
    for (int i = 0; i < NTAPS; i++) taps[i] = CW'(i + 1);
    got.delete();
    feed(1);
    feed(0);
    feed(0);
    chk("ramp0", got[0], 1);
    chk("ramp1", got[1], 2);
    chk("ramp2", got[2], 3);
    for (int i = 0; i < NTAPS; i++) taps[i] = 16'sd1;

    // Latency from accept edge to valid
    send(3);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (rv) ok = 1'b1;
    end
    chk("latency", n, 17);
    wait_result();

    // Reset in the middle of MAC discards everything
    send(7);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
    feed(5);
    chk("post_reset", got[0], 5);

    // Backpressure with a pending sample
    got.delete();
    acc_times.delete();
    rr = 1'b0;
    send(10);
    sv  = 1'b1;
    smp = 16'sd20;
    ok  = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (rv) ok = 1'b1;
    end
    if (!ok) chk("bp_valid_timeout", 0, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_ready_held", rdy, 0);
    chk("bp_valid_held", rv, 1);
    chk("bp_result_held", longint'(res), 15);
    rr = 1'b1;
    send(20);
    chk("bp_accept_after_hs", acc_times[1] - hs_cyc, 1);
    wait_result();
    chk("bp_first", got[0], 15);
    chk("bp_second", got[1], 35);

    // Overflow
    pulse_reset();
    got.delete();
    gsat.delete();
    repeat (16) feed(32767);
`ifdef FIR_SATURATE_EN
    chk("ovf_result", got[15], 32767);
    chk("ovf_sat", gsat[15], 1);
`else
    chk("ovf_result", got[15], -16);
    chk("ovf_sat", gsat[15], 0);
`endif

    repeat (3) @(posedge clk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Single-MAC FIR controller. It accepts one input sample at a time and shifts it into a sample history. It then walks the coefficient ROM index by index, multiplying each returned tap by the matching history sample and accumulating the products. The scaled result is delivered over a valid/ready handshake. It sits between the sample source and the downstream consumer and is the only driver of the `coefficients` ROM index.

## Interface
- `NTAPS`, 16: number of taps; 2..32 (ROM index is 5 bits).
- `DW`, 16: signed sample and result width.
- `CW`, 16: signed coefficient width; matches the ROM's `o_tap`.
- `SHIFT`, 0: arithmetic right shift applied to the accumulator before output.
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset. Asynchronous, active-high.
- `i_sample`, in, DW: signed input sample.
- `i_sample_valid`, in, 1: `i_sample` is valid.
- `o_sample_ready`, out, 1: block can accept a sample.
- `o_idx`, out, 5: coefficient index to the ROM; registered.
- `i_tap`, in, CW: signed coefficient from the ROM for the current `o_idx`, same cycle (combinational ROM).
- `o_result`, out, DW: signed filter output.
- `o_result_valid`, out, 1: `o_result` is valid.
- `i_result_ready`, in, 1: consumer accepts the result.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_sat`, out, 1: the current result was saturated.

## Operation
- The accumulator width is `AW = DW + CW + $clog2(NTAPS)`. Products are full DW+CW signed. No wrap is possible inside the accumulator.
- History `x[0..NTAPS-1]` is DW signed, with `x[0]` the newest sample. Reset clears it to 0, so unfilled history contributes 0.
- The result is `sum over i of tap[i] * x[i]`, shifted right arithmetically by SHIFT, then reduced to DW bits as described under Configuration.
- State machine:
  - IDLE: `o_sample_ready` = 1. On `i_sample_valid` = 1, shift the history, write the sample into `x[0]`, clear the accumulator, set `o_idx` = 0, and go to MAC.
  - MAC: each cycle, register the product `i_tap * x[o_idx]` and add the previous product to the accumulator. Increment `o_idx`. After the cycle where `o_idx` = NTAPS-1, go to DRAIN.
  - DRAIN: compute the final sum (accumulator plus last product), register `o_result`, set `o_result_valid` = 1, and go to OUT.
  - OUT: hold `o_result` and `o_result_valid` stable. On `i_result_ready` = 1, clear valid and go to IDLE.
- `o_idx` returns to 0 on entry to IDLE. It never exceeds NTAPS-1.
- Reset asserted in any state (including mid-MAC or in OUT):
  - the state returns to IDLE;
  - history and accumulator clear;
  - any pending result is discarded.

## Timing
- Reset values:
  - `o_idx` = 0, `o_result` = 0, `o_result_valid` = 0, `o_sat` = 0, `o_busy` = 0.
  - `o_sample_ready` = 1, because it decodes IDLE.
- Sample accepted at edge k:
  - `o_idx` = 0 during the cycle after edge k.
  - `o_idx` = NTAPS-1 during the cycle after edge k+NTAPS-1.
  - `o_result_valid` rises after edge k+NTAPS+1. Latency is NTAPS+1 cycles, i.e. 17 at defaults.
- Throughput: with `i_result_ready` held at 1, one sample every NTAPS+3 cycles.
- `o_sample_ready` is 0 from the edge after acceptance until the state is back in IDLE. A result handshake and a sample acceptance never happen in the same cycle.
- `i_sample_valid` asserted while not ready is ignored. The source must hold it until it is accepted.
- `o_sat` updates together with `o_result` and is held with it.

## Configuration
- `FIR_SATURATE_EN` defined: the shifted accumulator is clamped to [-2^(DW-1), 2^(DW-1)-1]. `o_sat` = 1 when the clamp is applied.
- Not defined: `o_result` is the low DW bits of the shifted accumulator (two's-complement wrap). `o_sat` is tied to 0.

## Structure
- Package `fir_pkg` holds:
  - the state enum (IDLE, MAC, DRAIN, OUT);
  - the index width constant (5);
  - a function computing AW from DW, CW and NTAPS.
- Sub-module `fir_delay_line` (parameters NTAPS, DW):
  - shift-enable input and sample input;
  - read-index input and read-data output;
  - asynchronous clear on `i_rst`.

## Test plan
- Reset, with `i_rst` pulsed mid-MAC: all outputs return to their reset values. The next sample 5 produces result 5 (history cleared).
- Impulse, taps all 1, SHIFT=0: feed 1 followed by 16 zeros. Required results are 1 sixteen times, then 0.
- Step, taps all 1: feed 100 twenty times. Required results are 100, 200, …, 1600, then 1600 four more times.
- Latency, `i_result_ready` = 1: `o_idx` steps through 0..15 on consecutive cycles, and valid is high exactly 17 cycles after the accept edge.
- Backpressure, `i_result_ready` held at 0 for 5 cycles: `o_result` and `o_result_valid` stay stable, `o_sample_ready` stays 0, and a pending `i_sample_valid` is not accepted until the cycle after the handshake.
- Overflow, feed 32767 sixteen times:
  - with `FIR_SATURATE_EN`, the final result is 32767 with `o_sat` = 1;
  - without it, the final result is -16 (0xFFF0) with `o_sat` = 0.
